// File: rtl/demux_pkg.sv
// Shared constants for the 1:4 word distributor: widths, channel count and channel indices.
package demux_pkg;

  localparam int WIDTH = 32;
  localparam int SEL_W = 2;
  localparam int N_OUT = 4;
  localparam int CNT_W = 16;

  localparam logic [SEL_W-1:0] CH0 = 2'd0;
  localparam logic [SEL_W-1:0] CH1 = 2'd1;
  localparam logic [SEL_W-1:0] CH2 = 2'd2;
  localparam logic [SEL_W-1:0] CH3 = 2'd3;

endpackage

// File: rtl/demux_slot.sv
// One-entry output holding register with valid/ready; a load in the same cycle as a drain
// keeps the slot full so each channel sustains one word per cycle.
module demux_slot #(
  parameter int WIDTH = demux_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  input  logic             ready
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (valid_q && ready) begin
      valid_d = 1'b0;
    end
    if (load) begin
      data_d  = din;
      valid_d = 1'b1;
    end
  end

  // Data is not cleared on drain; the last word stays visible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign dout  = data_q;
  assign valid = valid_q;

endmodule

// File: rtl/demux4_32_dist.sv
// Registered 1:4 word distributor: steers each accepted input word into one of four
// channel slots chosen by in_sel or by a strict-order round-robin pointer.
module demux4_32_dist #(
  parameter int WIDTH = demux_pkg::WIDTH,
  parameter int CNT_W = demux_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             rr_mode,
  output logic [WIDTH-1:0] z0,
  output logic [WIDTH-1:0] z1,
  output logic [WIDTH-1:0] z2,
  output logic [WIDTH-1:0] z3,
  output logic [3:0]       z_valid,
  input  logic [3:0]       z_ready,
  output logic [1:0]       rr_ptr,
  output logic [CNT_W-1:0] xfer_cnt
);

  import demux_pkg::*;

  logic [SEL_W-1:0] tgt;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;
  logic             acc;
  logic [N_OUT-1:0] load;
  logic [WIDTH-1:0] z_q [N_OUT];

  // Ready depends only on the target slot's state, never on in_data.
  assign tgt      = rr_mode ? rr_ptr_q : in_sel;
  assign in_ready = ~z_valid[tgt] | z_ready[tgt];
  assign acc      = in_valid & in_ready;

  for (genvar k = 0; k < N_OUT; k++) begin : g_slot
    assign load[k] = acc & (tgt == SEL_W'(k));

    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk    (clk),
      .reset_n(reset_n),
      .load   (load[k]),
      .din    (in_data),
      .dout   (z_q[k]),
      .valid  (z_valid[k]),
      .ready  (z_ready[k])
    );
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    xfer_cnt_d = xfer_cnt_q;
    if (acc) begin
      xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
      if (rr_mode) begin
        rr_ptr_d = rr_ptr_q + SEL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q   <= '0;
      xfer_cnt_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign z0       = z_q[CH0];
  assign z1       = z_q[CH1];
  assign z2       = z_q[CH2];
  assign z3       = z_q[CH3];
  assign rr_ptr   = rr_ptr_q;
  assign xfer_cnt = xfer_cnt_q;

endmodule

// File: tb/tb_demux4_32_dist.sv
// Bench for demux4_32_dist: directed vector table, hand sequences for back-to-back,
// mid-cycle reset and counter wrap, then random traffic against a slot-level model.
module tb_demux4_32_dist;

  localparam int W  = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [W-1:0]  in_data;
  logic [1:0]    in_sel;
  logic          in_valid;
  logic          in_ready;
  logic          rr_mode;
  logic [W-1:0]  z0, z1, z2, z3;
  logic [3:0]    z_valid;
  logic [3:0]    z_ready;
  logic [1:0]    rr_ptr;
  logic [CW-1:0] xfer_cnt;

  demux4_32_dist #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .in_data (in_data),
    .in_sel  (in_sel),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .rr_mode (rr_mode),
    .z0      (z0),
    .z1      (z1),
    .z2      (z2),
    .z3      (z3),
    .z_valid (z_valid),
    .z_ready (z_ready),
    .rr_ptr  (rr_ptr),
    .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference state: four holding slots, pointer and counter as plain variables.
  logic [W-1:0]  m_d [4];
  logic [3:0]    m_v;
  int            m_ptr;
  int            m_cnt;
  logic          last_rdy;

  typedef struct {
    logic          rr;
    logic [1:0]    sel;
    logic          vld;
    logic [W-1:0]  data;
    logic [3:0]    zr;
    logic          exp_rdy;
    logic [3:0]    exp_zv;
    int            ch;
    logic [W-1:0]  exp_z;
    logic [1:0]    exp_ptr;
    logic [CW-1:0] exp_cnt;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  function automatic logic [W-1:0] zsel(input int k);
    case (k)
      0: return z0;
      1: return z1;
      2: return z2;
      default: return z3;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) m_d[k] = '0;
    m_v   = '0;
    m_ptr = 0;
    m_cnt = 0;
  endtask

  task automatic chk_all();
    chk("m_z_valid", 32'(z_valid), 32'(m_v));
    chk("m_z0", z0, m_d[0]);
    chk("m_z1", z1, m_d[1]);
    chk("m_z2", z2, m_d[2]);
    chk("m_z3", z3, m_d[3]);
    chk("m_rr_ptr", 32'(rr_ptr), 32'(m_ptr));
    chk("m_xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
  endtask

  // Called just after an active edge with inputs already driven; advances one cycle.
  task automatic step();
    int   t;
    logic r;
    #1;
    t = rr_mode ? m_ptr : int'(in_sel);
    r = !m_v[t] || z_ready[t];
    last_rdy = in_ready;
    chk("m_in_ready", 32'(in_ready), 32'(r));
    @(posedge clk);
    for (int k = 0; k < 4; k++) if (m_v[k] && z_ready[k]) m_v[k] = 1'b0;
    if (in_valid && r) begin
      m_d[t] = in_data;
      m_v[t] = 1'b1;
      m_cnt  = (m_cnt + 1) % (1 << CW);
      if (rr_mode) m_ptr = (m_ptr + 1) % 4;
    end
    #1;
    chk_all();
  endtask

  task automatic drive(input logic rr, input logic [1:0] sel, input logic vld,
                       input logic [W-1:0] data, input logic [3:0] zr);
    rr_mode  = rr;
    in_sel   = sel;
    in_valid = vld;
    in_data  = data;
    z_ready  = zr;
  endtask

  initial begin
    //          rr    sel   vld   data          zr     rdy   zv     ch z             ptr   cnt
    tbl[0]  = '{1'b0, 2'd0, 1'b1, 32'h0,        4'hF,  1'b1, 4'h1,  0, 32'h0,        2'd0, 4'd1};
    tbl[1]  = '{1'b0, 2'd1, 1'b1, 32'h1,        4'hF,  1'b1, 4'h2,  1, 32'h1,        2'd0, 4'd2};
    tbl[2]  = '{1'b0, 2'd2, 1'b1, 32'h2,        4'hF,  1'b1, 4'h4,  2, 32'h2,        2'd0, 4'd3};
    tbl[3]  = '{1'b0, 2'd3, 1'b1, 32'h3,        4'hF,  1'b1, 4'h8,  3, 32'h3,        2'd0, 4'd4};
    tbl[4]  = '{1'b1, 2'd0, 1'b0, 32'h0,        4'hF,  1'b1, 4'h0,  3, 32'h3,        2'd0, 4'd4};
    tbl[5]  = '{1'b1, 2'd0, 1'b1, 32'hA0,       4'h0,  1'b1, 4'h1,  0, 32'hA0,       2'd1, 4'd5};
    tbl[6]  = '{1'b1, 2'd0, 1'b1, 32'hA1,       4'h0,  1'b1, 4'h3,  1, 32'hA1,       2'd2, 4'd6};
    tbl[7]  = '{1'b1, 2'd0, 1'b1, 32'hA2,       4'h0,  1'b1, 4'h7,  2, 32'hA2,       2'd3, 4'd7};
    tbl[8]  = '{1'b1, 2'd0, 1'b1, 32'hA3,       4'h0,  1'b1, 4'hF,  3, 32'hA3,       2'd0, 4'd8};
    tbl[9]  = '{1'b1, 2'd0, 1'b1, 32'hA4,       4'h0,  1'b0, 4'hF,  0, 32'hA0,       2'd0, 4'd8};
    tbl[10] = '{1'b1, 2'd0, 1'b1, 32'hA4,       4'h1,  1'b1, 4'hF,  0, 32'hA4,       2'd1, 4'd9};
    tbl[11] = '{1'b0, 2'd2, 1'b1, 32'hBEEF,     4'h0,  1'b0, 4'hF,  2, 32'hA2,       2'd1, 4'd9};
    tbl[12] = '{1'b0, 2'd2, 1'b0, 32'hBEEF,     4'h2,  1'b0, 4'hD,  1, 32'hA1,       2'd1, 4'd9};
    tbl[13] = '{1'b0, 2'd1, 1'b1, 32'hBEEF,     4'h0,  1'b1, 4'hF,  1, 32'hBEEF,     2'd1, 4'd10};
    tbl[14] = '{1'b0, 2'd3, 1'b1, 32'h55,       4'h8,  1'b1, 4'hF,  3, 32'h55,       2'd1, 4'd11};

    reset_n = 1'b0;
    drive(1'b0, 2'd0, 1'b0, '0, 4'h0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_z_valid", 32'(z_valid), 32'h0);
    chk("reset_z0", z0, 32'h0);
    chk("reset_z3", z3, 32'h0);
    chk("reset_rr_ptr", 32'(rr_ptr), 32'h0);
    chk("reset_xfer_cnt", 32'(xfer_cnt), 32'h0);
    chk("reset_in_ready", 32'(in_ready), 32'h1);

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].rr, tbl[i].sel, tbl[i].vld, tbl[i].data, tbl[i].zr);
      step();
      chk($sformatf("vec%0d_in_ready", i), 32'(last_rdy), 32'(tbl[i].exp_rdy));
      chk($sformatf("vec%0d_z_valid", i), 32'(z_valid), 32'(tbl[i].exp_zv));
      chk($sformatf("vec%0d_z%0d", i, tbl[i].ch), zsel(tbl[i].ch), tbl[i].exp_z);
      chk($sformatf("vec%0d_rr_ptr", i), 32'(rr_ptr), 32'(tbl[i].exp_ptr));
      chk($sformatf("vec%0d_xfer_cnt", i), 32'(xfer_cnt), 32'(tbl[i].exp_cnt));
    end

    // Channel 3 drained and reloaded every cycle.
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 2'd3, 1'b1, 32'h60 + 32'(i), 4'h8);
      step();
      chk("b2b_in_ready", 32'(last_rdy), 32'h1);
      chk("b2b_z_valid3", 32'(z_valid[3]), 32'h1);
      chk("b2b_z3", z3, 32'h60 + 32'(i));
      chk("b2b_xfer_cnt", 32'(xfer_cnt), 32'((12 + i) % 16));
    end

    // Reset asserted between edges while words are held.
    drive(1'b0, 2'd0, 1'b0, '0, 4'hF);
    step();
    drive(1'b1, 2'd0, 1'b1, 32'h11, 4'h0);
    step();
    drive(1'b0, 2'd1, 1'b1, 32'h77, 4'h2);
    step();
    drive(1'b0, 2'd1, 1'b0, '0, 4'h0);
    chk("pre_rst_z1", z1, 32'h77);
    chk("pre_rst_rr_ptr", 32'(rr_ptr), 32'h2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_z_valid", 32'(z_valid), 32'h0);
    chk("async_rst_z1", z1, 32'h0);
    chk("async_rst_rr_ptr", 32'(rr_ptr), 32'h0);
    chk("async_rst_xfer_cnt", 32'(xfer_cnt), 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk);
    #1;
    chk_all();

    // Counter wrap after 16 accepts.
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 2'(i % 4), 1'b1, 32'h100 + 32'(i), 4'hF);
      step();
      chk("wrap_xfer_cnt", 32'(xfer_cnt), 32'((i + 1) % 16));
    end

    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 3) != 0), $urandom, 4'($urandom_range(0, 15)));
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/demux4_32_dist.md
# demux4_32_dist

Registered 1:4 word distributor: the inverse of the 32-bit 4:1 datapath mux. It accepts one 32-bit word per cycle on a valid/ready input and steers it into one of four output channels. Each channel has its own one-entry holding register and valid/ready handshake. The target channel comes from an explicit 2-bit select or from an internal round-robin pointer. It sits between a single word producer and four independent datapath consumers.

## Interface
Parameters:
- `WIDTH`, 32, data word width
- `CNT_W`, 16, width of the accepted-word counter

Ports:
- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `in_data`  in  WIDTH  word to distribute
- `in_sel`  in  2  target channel when `rr_mode`=0
- `in_valid`  in  1  `in_data`/`in_sel` valid
- `in_ready`  out  1  word accepted this cycle when `in_valid`&`in_ready`
- `rr_mode`  in  1  1 = target is `rr_ptr`, `in_sel` ignored
- `z0`,`z1`,`z2`,`z3`  out  WIDTH  channel data registers
- `z_valid`  out  4  bit k = channel k holds an undelivered word
- `z_ready`  in  4  bit k = consumer k takes the word this cycle
- `rr_ptr`  out  2  current round-robin target
- `xfer_cnt`  out  CNT_W  total accepted words, wraps

## Operation
- Target channel: `tgt = rr_mode ? rr_ptr : in_sel`.
- Accept condition: `acc = in_valid & in_ready`.
- `in_ready = ~z_valid[tgt] | z_ready[tgt]`. This path is combinational from `rr_mode`, `in_sel`, `rr_ptr`, `z_valid` and `z_ready`. There is no path from `in_data`.
- On `acc`: `z[tgt]` <= `in_data`, `z_valid[tgt]` <= 1.
- Channel k drains on `z_valid[k] & z_ready[k]`. If channel k is not loaded in the same cycle, `z_valid[k]` <= 0.
- Drain and load of the same channel in the same cycle: `z_valid` stays 1 and the data register takes the new word (full throughput per channel).
- Drains on other channels proceed independently in the same cycle.
- `zk` holds stable while `z_valid[k]`=1 and `z_ready[k]`=0.
- After a drain, `zk` retains its last value; it is not cleared.
- `z_ready[k]` while `z_valid[k]`=0 is ignored.
- Round-robin:
  - `rr_ptr` advances by 1, wrapping 3->0, on every `acc` while `rr_mode`=1.
  - `rr_ptr` is held while `rr_mode`=0.
  - Order is strict: if `z_valid[rr_ptr]`=1 and not draining, input stalls. The pointer never skips a full channel.
  - Switching `rr_mode` 0->1 resumes from the held `rr_ptr`.
- `xfer_cnt` increments by 1 on every `acc` in either mode and wraps from 2^CNT_W-1 to 0.

## Timing
- Reset (asynchronous assert, synchronous release edge):
  - `z_valid`=0, `z0`..`z3`=0, `rr_ptr`=0, `xfer_cnt`=0.
  - `in_ready` then evaluates to 1.
- Latency: a word accepted at edge N is visible on `zk` with `z_valid[k]`=1 after edge N. A consumer can take it at edge N+1.
- Throughput: 1 word/cycle with all consumers ready. In round-robin with all four consumers stalled, exactly 4 words are accepted before `in_ready`=0.
- Reset mid-operation: all held words are discarded, with no partial transfer. `in_ready` is 1 immediately after release.
- No other registered outputs exist. Only `in_ready` is combinational.

## Structure
- Package `demux_pkg`:
  - `WIDTH` default 32, `SEL_W`=2, `N_OUT`=4
  - channel index constants `CH0`..`CH3`
  - `CNT_W` default
- Sub-module `demux_slot`: one-entry register slice with `load`, `din`, `dout`, `valid`, `ready`, `reset_n`. It implements the drain/load/simultaneous rules above and is instantiated 4 times.
- The top level holds the target decode, the `in_ready` mux, `rr_ptr` and `xfer_cnt`.

## Test plan
1. Reset, then `rr_mode`=0, all `z_ready`=1. Send `in_sel`=0,1,2,3 with data 0x0,0x1,0x2,0x3 on consecutive cycles. Required: each `zk`=k with a single-cycle `z_valid[k]` pulse, `xfer_cnt`=4.
2. `rr_mode`=1, all `z_ready`=0. Offer 0xA0..0xA4 continuously. Required:
   - 4 accepts; `z0..z3`=0xA0..0xA3; `in_ready`=0 with `rr_ptr`=0.
   - Raise `z_ready[0]`: 0xA4 is accepted into `z0` in the same cycle and `z_valid[0]` stays 1.
3. `rr_mode`=0, `in_sel`=2, `z_ready[2]`=0, `z2` full. Offer 0xBEEF. Required:
   - `in_ready`=0 and `z2` is unchanged.
   - Switching `in_sel`=1 gives `in_ready`=1 and `z1`=0xBEEF.
4. Channel 3 full. Same cycle: `z_ready[3]`=1 and a new accept of 0x55 to channel 3. Required: `z_valid[3]` stays 1 and `z3`=0x55 next cycle. Repeat back-to-back for 8 cycles at 1 word/cycle.
5. Load `z1`=0x77, then assert `reset_n`=0 mid-stream, asynchronously between edges. Required: `z_valid`=0, `z1`=0, `rr_ptr`=0 and `xfer_cnt`=0 immediately. After release, `in_ready`=1.
6. Force `xfer_cnt` near the top by sending 2^CNT_W accepts with `CNT_W`=4. Required: wraps 15->0 on the 16th accept.
